seg_capture: RTL and testbench
==============================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4: consecutive identical samples needed to accept a digit; legal range 2..255.
REQ-002 Parameter TIMEOUT_CYC, default 8192: maximum cycles allowed in WAIT_TENS; legal range 16..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 seg_in  input  8  multiplexed segment bus, active-low; bit0=a .. bit6=g, bit7=dp; synchronous to clk.
REQ-006 sel_in  input  4  digit select; [1:0]=01 means ones digit shown, 10 means tens digit shown, 00/11 means blank; [3:2] ignored.
REQ-007 count_out  output  4  reconstructed count 0..15, registered.
REQ-008 count_valid  output  1  one-cycle pulse; count_out updated in the same cycle.
REQ-009 seg_err  output  1  one-cycle pulse on any error.
REQ-010 err_code  output  2  last error: 00 none, 01 illegal pattern, 10 range, 11 timeout; holds until the next error or reset.

Function
REQ-011 Legal patterns (seg_in hex, dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90; any other value is illegal.
REQ-012 Stability filter: {sel_in[1:0], seg_in} compared to the previous sample each cycle; any change or blank select reloads the counter to 1; the counter saturates at STABLE_CYC.
REQ-013 Digit accepted on the edge where the counter reaches STABLE_CYC; at most one acceptance per unbroken stable period.
REQ-014 FSM states WAIT_ONES (reset state) and WAIT_TENS.
REQ-015 WAIT_ONES: accepted ones digit stored in ones_reg -> WAIT_TENS; accepted tens digit ignored, no error.
REQ-016 WAIT_TENS: a further accepted ones digit overwrites ones_reg and restarts the timeout, staying in WAIT_TENS; an accepted tens digit -> WAIT_ONES.
REQ-017 Tens value: pattern C0 -> 0, F9 -> 1; any other legal digit on tens -> range error, no count_valid.
REQ-018 count_out = tens*10 + ones, computed in 5 bits; result > 15 -> range error, count_out unchanged.
REQ-019 Latency: count_valid and the new count_out are asserted on the edge after tens acceptance.
REQ-020 Illegal pattern accepted on either digit -> seg_err, err_code=01, FSM -> WAIT_ONES, ones_reg unchanged.
REQ-021 Timeout counter cleared on entry to WAIT_TENS; on reaching TIMEOUT_CYC -> seg_err, err_code=11, -> WAIT_ONES.
REQ-022 seg_err and count_valid are never high in the same cycle.
REQ-023 A range error (err_code=10) also returns the FSM to WAIT_ONES.

Reset
REQ-024 reset=0 asynchronously forces count_out=0, count_valid=0, seg_err=0, err_code=00, FSM=WAIT_ONES, and ones_reg, stability counter, timeout counter and previous sample to 0.
REQ-025 Reset mid-frame discards the captured ones digit; the first accepted digit after release is treated per REQ-015.
REQ-026 Blank selects after reset never produce acceptance.

Configuration
REQ-027 Macro SEG_CAPTURE_DP_CHECK_EN defined: seg_in[7]=0 (dp lit) on an accepted digit is an illegal pattern (err_code=01).
REQ-028 Macro undefined: seg_in[7] is forced to 1 before the stability compare and the decode, so dp is ignored entirely.

Verification
REQ-029 Ones F9 for 6 cycles, then tens F9 for 6 cycles -> count_valid once, count_out=11, err_code=00.
REQ-030 Ones 92 for 3 cycles, one cycle blank, then 92 for 3 cycles (STABLE_CYC=4) -> no acceptance, FSM stays WAIT_ONES.
REQ-031 Ones 82, then tens F9 -> seg_err, err_code=10, count_out keeps its previous value.
REQ-032 Ones B0, then blank for TIMEOUT_CYC cycles -> seg_err at cycle TIMEOUT_CYC, err_code=11; a later tens C0 alone is ignored.
REQ-033 Ones 0x55 held stable -> seg_err, err_code=01; with SEG_CAPTURE_DP_CHECK_EN, ones 0x40 -> err_code=01; without the macro, 0x40 decodes as 0.
REQ-034 reset pulled low while in WAIT_TENS -> outputs 0 immediately; after release, tens F9 alone -> no count_valid.

Source files
------------

// File: rtl/seg_capture.sv
// ---------------------------------------------------------------------------
// seg_capture
//
// Watches a multiplexed, active-low 7-segment display bus and rebuilds the
// two-digit count (0..15) that the display is showing.
//
// Each display sample is {sel_in[1:0], seg_in}. A digit is taken once that
// sample has been seen STABLE_CYC cycles in a row on a non-blank select.
//
// A frame is a ones digit followed by a tens digit. The result is published
// on count_out/count_valid one edge after the tens digit is taken. Illegal
// patterns, out-of-range results and a missing tens digit raise a one-cycle
// seg_err pulse. err_code holds the most recent error.
//
// Optional feature:
//   SEG_CAPTURE_DP_CHECK_EN  defined   -> a lit decimal point (seg_in[7]=0)
//                                         on a taken digit is an illegal
//                                         pattern.
//                            undefined -> seg_in[7] is treated as always 1,
//                                         so the decimal point is ignored.
// ---------------------------------------------------------------------------
module seg_capture #(
    parameter int unsigned STABLE_CYC  = 4,     // 2..255
    parameter int unsigned TIMEOUT_CYC = 8192   // 16..65535
) (
    input  logic       clk,
    input  logic       reset,        // asynchronous, active-low
    input  logic [7:0] seg_in,
    input  logic [3:0] sel_in,
    output logic [3:0] count_out,
    output logic       count_valid,
    output logic       seg_err,
    output logic [1:0] err_code
);

    typedef enum logic {
        WAIT_ONES = 1'b0,
        WAIT_TENS = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_RANGE   = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_t;

    localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYC);
    localparam logic [7:0]  STAB_PRE = 8'(STABLE_CYC - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);

    // -----------------------------------------------------------------------
    // Decimal-point handling
    // -----------------------------------------------------------------------
    logic [7:0] w_seg;
    logic       w_unused_in;

`ifdef SEG_CAPTURE_DP_CHECK_EN
    // The dp bit is kept. A lit dp then never matches a legal pattern.
    assign w_seg       = seg_in;
    assign w_unused_in = ^sel_in[3:2];
`else
    // The dp bit is forced off, so dp changes do not break stability.
    assign w_seg       = {1'b1, seg_in[6:0]};
    assign w_unused_in = ^{sel_in[3:2], seg_in[7]};
`endif

    // -----------------------------------------------------------------------
    // Stability filter
    // -----------------------------------------------------------------------
    logic [9:0] r_prev_sample;
    logic [7:0] r_stab_cnt;
    logic [9:0] w_sample;
    logic       w_blank;
    logic       w_same;
    logic       w_is_ones;
    logic       w_accept;

    assign w_sample  = {sel_in[1:0], w_seg};
    assign w_blank   = (sel_in[1:0] == 2'b00) || (sel_in[1:0] == 2'b11);
    assign w_same    = (w_sample == r_prev_sample);
    assign w_is_ones = (sel_in[1:0] == 2'b01);

    // A digit is taken only on the edge where the run length reaches
    // STABLE_CYC. The counter then saturates, so one unbroken run is
    // accepted at most once.
    assign w_accept  = !w_blank && w_same && (r_stab_cnt == STAB_PRE);

    // Track the previous sample and the length of the current stable run.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev_sample <= '0;
            r_stab_cnt    <= '0;
        end else begin
            r_prev_sample <= w_sample;
            if (w_blank || !w_same) begin
                r_stab_cnt <= 8'd1;
            end else if (r_stab_cnt != STAB_MAX) begin
                r_stab_cnt <= r_stab_cnt + 8'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pattern decode
    // -----------------------------------------------------------------------
    logic       w_legal;
    logic [3:0] w_digit;

    // Map a 7-segment pattern (with dp) onto a decimal digit.
    // NOTE: every output gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        w_legal = 1'b1;
        w_digit = 4'd0;
        case (w_seg)
            8'hC0:   w_digit = 4'd0;
            8'hF9:   w_digit = 4'd1;
            8'hA4:   w_digit = 4'd2;
            8'hB0:   w_digit = 4'd3;
            8'h99:   w_digit = 4'd4;
            8'h92:   w_digit = 4'd5;
            8'h82:   w_digit = 4'd6;
            8'hF8:   w_digit = 4'd7;
            8'h80:   w_digit = 4'd8;
            8'h90:   w_digit = 4'd9;
            default: w_legal = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Frame assembly
    // -----------------------------------------------------------------------
    state_t     r_state;
    logic [3:0] r_ones;
    logic [15:0] r_to_cnt;
    logic       r_pend;       // tens digit taken last edge; publish result now
    logic       r_pend_bad;   // that result is out of range
    logic [4:0] r_pend_sum;

    logic       w_tens_ok;
    logic [4:0] w_sum;

    // Only 0 and 1 are valid tens digits. The sum is held in 5 bits, so
    // 16..19 can be detected as a range error.
    assign w_tens_ok = (w_digit <= 4'd1);
    assign w_sum     = ((w_digit == 4'd1) ? 5'd10 : 5'd0) + {1'b0, r_ones};

    // Ones/tens sequencing, timeout and registered result/error outputs.
    // NOTE: reset clears every register, including the captured ones digit
    // and the counters, so a frame interrupted by reset leaves no residue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= WAIT_ONES;
            r_ones      <= '0;
            r_to_cnt    <= '0;
            r_pend      <= 1'b0;
            r_pend_bad  <= 1'b0;
            r_pend_sum  <= '0;
            count_out   <= '0;
            count_valid <= 1'b0;
            seg_err     <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            count_valid <= 1'b0;
            seg_err     <= 1'b0;
            r_pend      <= 1'b0;

            // Publish the frame captured on the previous edge.
            // A new digit cannot be taken on this edge, because a stable run
            // needs at least two cycles after the tens digit, so the pulses
            // below never coincide with a decode error.
            if (r_pend) begin
                if (r_pend_bad || (r_pend_sum > 5'd15)) begin
                    seg_err  <= 1'b1;
                    err_code <= ERR_RANGE;
                end else begin
                    count_out   <= r_pend_sum[3:0];
                    count_valid <= 1'b1;
                end
            end

            case (r_state)
                WAIT_ONES: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            seg_err  <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                        end else if (w_is_ones) begin
                            r_ones   <= w_digit;
                            r_to_cnt <= '0;
                            r_state  <= WAIT_TENS;
                        end
                        // A legal tens digit without a ones digit is dropped.
                    end
                end

                WAIT_TENS: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            seg_err  <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                            r_state  <= WAIT_ONES;
                        end else if (w_is_ones) begin
                            r_ones   <= w_digit;
                            r_to_cnt <= '0;
                        end else begin
                            r_pend     <= 1'b1;
                            r_pend_bad <= !w_tens_ok;
                            r_pend_sum <= w_sum;
                            r_state    <= WAIT_ONES;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        seg_err  <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        r_state  <= WAIT_ONES;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end

                default: r_state <= WAIT_ONES;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// ---------------------------------------------------------------------------
// tb_seg_capture
//
// Self-checking bench for seg_capture.
//
// A behavioural model tracks run lengths, the capture mode, the timeout
// deadline (as an absolute cycle number) and the one-edge-delayed result.
// A monitor compares every output against that model on every clock cycle
// while reset is released.
//
// Directed sequences pin the model with hand-computed literal values.
// Randomized display traffic follows them.
//
// Honours SEG_CAPTURE_DP_CHECK_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_seg_capture;

    localparam int STB = 4;
    localparam int TMO = 64;

`ifdef SEG_CAPTURE_DP_CHECK_EN
    localparam bit DP_CHECK = 1'b1;
`else
    localparam bit DP_CHECK = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] seg_in;
    logic [3:0] sel_in;
    logic [3:0] count_out;
    logic       count_valid;
    logic       seg_err;
    logic [1:0] err_code;

    seg_capture #(
        .STABLE_CYC (STB),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .sel_in     (sel_in),
        .count_out  (count_out),
        .count_valid(count_valid),
        .seg_err    (seg_err),
        .err_code   (err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [7:0] pats [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic int digit_of(input logic [7:0] v);
        for (int i = 0; i < 10; i++) begin
            if (pats[i] == v) return i;
        end
        return -1;
    endfunction

    int         m_cycle;
    int         m_run;
    logic [9:0] m_last;
    bit         m_tens_mode;
    int         m_ones;
    int         m_deadline;
    bit         m_pend;
    bit         m_pend_ok;
    int         m_pend_val;
    int         m_count;
    int         m_code;
    bit         m_cv;
    bit         m_se;

    task automatic model_reset();
        m_cycle     = 0;
        m_run       = 0;
        m_last      = '0;
        m_tens_mode = 1'b0;
        m_ones      = 0;
        m_deadline  = 0;
        m_pend      = 1'b0;
        m_pend_ok   = 1'b0;
        m_pend_val  = 0;
        m_count     = 0;
        m_code      = 0;
        m_cv        = 1'b0;
        m_se        = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] seg, input logic [1:0] sel);
        logic [7:0] eff;
        logic [9:0] samp;
        bit         blank;
        int         d;
        int         val;

        m_cycle++;
        m_cv = 1'b0;
        m_se = 1'b0;

        // Result of the frame finished on the previous edge.
        if (m_pend) begin
            m_pend = 1'b0;
            if (m_pend_ok) begin
                m_count = m_pend_val;
                m_cv    = 1'b1;
            end else begin
                m_se   = 1'b1;
                m_code = 2;
            end
        end

        eff   = DP_CHECK ? seg : (seg | 8'h80);
        blank = (sel == 2'b00) || (sel == 2'b11);
        samp  = {sel, eff};
        if (blank) m_run = 0;
        else if (samp == m_last) m_run++;
        else m_run = 1;
        m_last = samp;

        if (m_run == STB) begin
            d = digit_of(eff);
            if (d < 0) begin
                m_se        = 1'b1;
                m_code      = 1;
                m_tens_mode = 1'b0;
            end else if (sel == 2'b01) begin
                m_ones      = d;
                m_tens_mode = 1'b1;
                m_deadline  = m_cycle + TMO;
            end else if (m_tens_mode) begin
                m_tens_mode = 1'b0;
                m_pend      = 1'b1;
                if (d > 1) begin
                    m_pend_ok = 1'b0;
                end else begin
                    val        = d * 10 + m_ones;
                    m_pend_ok  = (val <= 15);
                    m_pend_val = val;
                end
            end
        end else if (m_tens_mode && (m_cycle == m_deadline)) begin
            m_se        = 1'b1;
            m_code      = 3;
            m_tens_mode = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: advance the model on each edge, compare #1 later
    // ------------------------------------------------------------------
    int cv_seen = 0;
    int se_seen = 0;

    initial model_reset();

    always @(posedge clk) begin
        if (!reset) begin
            model_reset();
        end else begin
            model_step(seg_in, sel_in[1:0]);
            #1;
            check("cycle_outputs",
                  {24'd0, count_valid, seg_err, err_code, count_out},
                  {24'd0, m_cv, m_se, 2'(m_code), 4'(m_count)});
            if (count_valid && seg_err) check("valid_err_exclusive", 32'd1, 32'd0);
            if (count_valid) cv_seen++;
            if (seg_err) se_seen++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic put(input logic [3:0] sel, input logic [7:0] seg, input int n);
        @(negedge clk);
        sel_in = sel;
        seg_in = seg;
        repeat (n) @(posedge clk);
    endtask

    int cv0;
    int se0;

    task automatic mark();
        cv0 = cv_seen;
        se0 = se_seen;
    endtask

    initial begin
        int r;
        int hold;
        logic [7:0] seg;
        logic [3:0] sel;

        reset  = 1'b1;
        seg_in = 8'hFF;
        sel_in = 4'h0;
        #2 reset = 1'b0;
        #1;
        check("reset_outputs", {24'd0, count_valid, seg_err, err_code, count_out}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Ones 1 then tens 1 -> count 11.
        mark();
        put(4'b0001, 8'hF9, 6);
        put(4'b0010, 8'hF9, 6);
        put(4'b0000, 8'hFF, 2);
        check("f9f9_valid_count", cv_seen - cv0, 1);
        check("f9f9_count_out", count_out, 11);
        check("f9f9_err_code", err_code, 0);

        // Interrupted runs never accept, and a tens digit in WAIT_ONES is dropped.
        mark();
        put(4'b0001, 8'h92, 3);
        put(4'b0000, 8'h92, 1);
        put(4'b0001, 8'h92, 3);
        put(4'b0010, 8'hF9, 6);
        put(4'b0000, 8'hFF, 2);
        check("broken_run_no_valid", cv_seen - cv0, 0);
        check("broken_run_no_err", se_seen - se0, 0);

        // Ones 6 with tens 1 -> 16 is a range error, count_out holds.
        mark();
        put(4'b0001, 8'h82, 6);
        put(4'b0010, 8'hF9, 6);
        put(4'b0000, 8'hFF, 2);
        check("range_err_pulse", se_seen - se0, 1);
        check("range_err_code", err_code, 2);
        check("range_count_held", count_out, 11);

        // Timeout, after which a lone tens digit is ignored.
        mark();
        put(4'b0001, 8'hB0, 6);
        put(4'b0000, 8'hFF, TMO);
        check("timeout_pulse", se_seen - se0, 1);
        check("timeout_code", err_code, 3);
        mark();
        put(4'b0010, 8'hC0, 6);
        put(4'b0000, 8'hFF, 2);
        check("post_timeout_no_valid", cv_seen - cv0, 0);
        check("post_timeout_code_held", err_code, 3);

        // Illegal pattern, then dp-lit zero.
        mark();
        put(4'b0001, 8'h55, 6);
        put(4'b0000, 8'hFF, 2);
        check("illegal_pulse", se_seen - se0, 1);
        check("illegal_code", err_code, 1);
        mark();
        put(4'b0001, 8'h40, 6);
        put(4'b0010, 8'hF9, 6);
        put(4'b0000, 8'hFF, 2);
`ifdef SEG_CAPTURE_DP_CHECK_EN
        check("dp_lit_err", se_seen - se0, 1);
        check("dp_lit_code", err_code, 1);
        check("dp_lit_no_valid", cv_seen - cv0, 0);
`else
        check("dp_ignored_valid", cv_seen - cv0, 1);
        check("dp_ignored_count", count_out, 10);
`endif

        // Reset while waiting for tens.
        put(4'b0001, 8'hF9, 6);
        @(negedge clk) reset = 1'b0;
        #1;
        check("midframe_reset_outputs",
              {24'd0, count_valid, seg_err, err_code, count_out}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        mark();
        put(4'b0010, 8'hF9, 6);
        put(4'b0000, 8'hFF, 2);
        check("after_reset_tens_ignored", cv_seen - cv0, 0);
        check("after_reset_no_err", se_seen - se0, 0);

        // Randomized display traffic, checked cycle by cycle by the monitor.
        for (int k = 0; k < 1500; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6) seg = pats[$urandom_range(0, 9)];
            else if (r < 8) seg = ($urandom_range(0, 1) != 0) ? 8'hC0 : 8'hF9;
            else seg = 8'($urandom);
            if ($urandom_range(0, 9) == 0) seg[7] = 1'b0;
            r = $urandom_range(0, 9);
            sel[3:2] = 2'($urandom);
            if (r < 4) sel[1:0] = 2'b01;
            else if (r < 8) sel[1:0] = 2'b10;
            else if (r == 8) sel[1:0] = 2'b00;
            else sel[1:0] = 2'b11;
            hold = ($urandom_range(0, 29) == 0) ? 70 : $urandom_range(1, 8);
            put(sel, seg, hold);
        end
        put(4'b0000, 8'hFF, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
